// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART TX arbiter slice.
//   arb_state_e : arbiter FSM states
//   UART_DATA_W : default byte width
//   rr_wrap()   : single-step modular wrap for round-robin indices
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // Indices never exceed 2*n-2, so one conditional subtract replaces a modulo.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin selector. Searches req_valid & elig_mask starting
// at rr_ptr and wrapping, and reports the first hit.
// Ports:
//   req_valid   in  N_REQ  requesters with a byte available
//   rr_ptr      in  IDX_W  highest-priority index this round
//   elig_mask   in  N_REQ  requesters allowed to win (packet lock)
//   pick_onehot out N_REQ  one-hot winner (all zero when no winner)
//   pick_idx    out IDX_W  winner index
//   pick_any    out 1      a winner exists
// -----------------------------------------------------------------------------
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [N_REQ-1:0] elig_mask,
    output logic [N_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] slot;

    assign cand = req_valid & elig_mask;

    // Scan from the farthest offset down so the candidate closest to rr_ptr
    // is the last one written and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise the
        // no-winner path would leave them unassigned and infer latches.
        pick_onehot = '0;
        pick_idx    = '0;
        pick_any    = 1'b0;
        slot        = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            slot = IDX_W'(rr_wrap(int'(rr_ptr) + off, N_REQ));
            if (cand[slot]) begin
                pick_onehot       = '0;
                pick_onehot[slot] = 1'b1;
                pick_idx          = slot;
                pick_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter between N_REQ byte
// sources. A grant latches the winning byte, pulses tx_start for one cycle,
// waits for tx_busy to rise (bounded by BUSY_TIMEOUT) and then to fall before
// the next grant.
// Optional feature macro: UART_TX_ARB_LOCK_EN (packet lock: after a byte with
// req_last=0 only the same requester is eligible and rr_ptr holds, until a
// req_last=1 byte is accepted or a busy timeout occurs).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           allow new grants
//   req_valid    per-requester byte available
//   req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_last     last byte of packet (lock build only)
//   req_ready    one-hot accept strobe, IDLE only
//   tx_data      byte to the transmitter, held until next grant
//   tx_start     one-cycle start pulse
//   tx_busy      transmitter frame in progress
//   grant_id     index of current or last grant
//   arb_busy     FSM not in IDLE
//   err_timeout  one-cycle pulse when tx_busy fails to rise in time
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      arb_busy,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] to_cnt;
    logic [N_REQ-1:0] elig_mask;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant;
    logic             timeout_hit;
    logic             rr_advance;
    logic [DATA_W-1:0] req_bytes [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_W +: DATA_W];
    end

`ifdef UART_TX_ARB_LOCK_EN
    logic locked;

    // While locked, grant_id still names the owning requester.
    assign elig_mask  = locked ? (N_REQ'(1) << grant_id) : '1;
    assign rr_advance = req_last[pick_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
        end else if (timeout_hit) begin
            locked <= 1'b0;
        end else if (grant) begin
            locked <= ~req_last[pick_idx];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign elig_mask   = '1;
    assign rr_advance  = 1'b1;
`endif

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .elig_mask   (elig_mask),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_any    (pick_any)
    );

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        grant       = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                // rst_n gate keeps req_ready at its reset value while reset is
                // held, even though the FSM already sits in IDLE.
                if (rst_n && en && pick_any) begin
                    grant     = 1'b1;
                    req_ready = pick_onehot;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt == CNT_W'(BUSY_TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_start    = (state == START);
    assign arb_busy    = (state != IDLE);
    assign err_timeout = timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge value regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            to_cnt   <= '0;
        end else begin
            if (grant) begin
                tx_data  <= req_bytes[pick_idx];
                grant_id <= pick_idx;
                if (rr_advance) rr_ptr <= IDX_W'(rr_wrap(int'(pick_idx) + 1, N_REQ));
            end
            if (state == START) begin
                to_cnt <= '0;
            end else if (state == WAIT_BUSY && !tx_busy && !timeout_hit) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
        end
    end

endmodule
